// File: rtl/adc_scan_avg.sv
// Round-robin ADC scan controller: issues one single-beat command per conversion,
// averages 2**AVG_LOG2 matching responses per channel and strobes the result.
module adc_scan_avg #(
    parameter int NCH      = 2,
    parameter int CH_BASE  = 1,
    parameter int AVG_LOG2 = 4
) (
    input  logic        clock_clk,
    input  logic        reset_sink_reset_n,
    input  logic        enable,
    output logic        command_valid,
    output logic [4:0]  command_channel,
    output logic        command_startofpacket,
    output logic        command_endofpacket,
    input  logic        command_ready,
    input  logic        response_valid,
    input  logic [4:0]  response_channel,
    input  logic [11:0] response_data,
    output logic        avg_valid,
    output logic [4:0]  avg_channel,
    output logic [11:0] avg_data,
    output logic        err_chan
);

    localparam int AW = 12 + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] NSAMP    = CW'(1 << AVG_LOG2);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);
    localparam logic [4:0]    BASE     = 5'(CH_BASE);

    typedef enum logic [1:0] {IDLE, CMD, WAIT_RSP, EMIT} state_t;

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic [AW-1:0] acc_q;
    logic [CW-1:0] cnt_q;
    logic [4:0]    avgChannel_q;
    logic [11:0]   avgData_q;
    logic          errChan_q;

    logic [4:0]    curChan_d;
    logic          rspMatch_d;
    logic [AW-1:0] accSum_d;
    logic [11:0]   avgTrunc_d;
    logic [CW-1:0] cntInc_d;

    assign curChan_d  = BASE + 5'(idx_q);
    assign rspMatch_d = (response_channel == curChan_d);
    assign accSum_d   = acc_q + AW'(response_data);
    assign avgTrunc_d = 12'(accSum_d >> AVG_LOG2);
    assign cntInc_d   = cnt_q + CW'(1);

    always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            avgChannel_q <= '0;
            avgData_q    <= '0;
            errChan_q    <= 1'b0;
        end else begin
            // A response is only legal while a conversion is outstanding.
            if (response_valid && (state_q != WAIT_RSP)) begin
                errChan_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q <= CMD;
                        idx_q   <= '0;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                CMD: begin
                    if (command_ready) begin
                        state_q <= WAIT_RSP;
                    end else if (!enable) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                WAIT_RSP: begin
                    if (response_valid) begin
                        if (rspMatch_d && (cntInc_d == NSAMP)) begin
                            state_q      <= EMIT;
                            acc_q        <= accSum_d;
                            cnt_q        <= cntInc_d;
                            avgChannel_q <= curChan_d;
                            avgData_q    <= avgTrunc_d;
                        end else if (enable) begin
                            state_q <= CMD;
                            if (rspMatch_d) begin
                                acc_q <= accSum_d;
                                cnt_q <= cntInc_d;
                            end else begin
                                errChan_q <= 1'b1;
                            end
                        end else begin
                            state_q <= IDLE;
                            idx_q   <= '0;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            if (!rspMatch_d) begin
                                errChan_q <= 1'b1;
                            end
                        end
                    end
                end
                EMIT: begin
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    idx_q   <= (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
                    state_q <= enable ? CMD : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Command and strobe outputs decode from state alone so reset clears them at once.
    assign command_valid         = (state_q == CMD);
    assign command_channel       = command_valid ? curChan_d : 5'd0;
    assign command_startofpacket = command_valid;
    assign command_endofpacket   = command_valid;
    assign avg_valid             = (state_q == EMIT);
    assign avg_channel           = avgChannel_q;
    assign avg_data              = avgData_q;
    assign err_chan              = errChan_q;

endmodule

// File: tb/tb_adc_scan_avg.sv
// Self-checking bench for adc_scan_avg: directed scenarios with literal expectations,
// then randomized traffic, all compared each cycle against a transaction-level model.
module tb_adc_scan_avg;

    localparam int NCH      = 2;
    localparam int CH_BASE  = 1;
    localparam int AVG_LOG2 = 2;
    localparam int NSAMP    = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        command_valid;
    logic [4:0]  command_channel;
    logic        command_startofpacket;
    logic        command_endofpacket;
    logic        command_ready;
    logic        response_valid;
    logic [4:0]  response_channel;
    logic [11:0] response_data;
    logic        avg_valid;
    logic [4:0]  avg_channel;
    logic [11:0] avg_data;
    logic        err_chan;

    always #5 clk = ~clk;

    adc_scan_avg #(.NCH(NCH), .CH_BASE(CH_BASE), .AVG_LOG2(AVG_LOG2)) dut (
        .clock_clk             (clk),
        .reset_sink_reset_n    (rst_n),
        .enable                (enable),
        .command_valid         (command_valid),
        .command_channel       (command_channel),
        .command_startofpacket (command_startofpacket),
        .command_endofpacket   (command_endofpacket),
        .command_ready         (command_ready),
        .response_valid        (response_valid),
        .response_channel      (response_channel),
        .response_data         (response_data),
        .avg_valid             (avg_valid),
        .avg_channel           (avg_channel),
        .avg_data              (avg_data),
        .err_chan              (err_chan)
    );

    // Scan model: which phase of a sample we are in, running sum and count per channel.
    typedef enum {M_OFF, M_REQ, M_WAIT, M_EMIT} phase_t;
    phase_t mPhase;
    int     mIdx, mSum, mCnt, mAvgCh, mAvgData;
    bit     mErr;

    int testsRun    = 0;
    int testsFailed = 0;

    task automatic check(input string name, input int act, input int exp);
        testsRun++;
        if (act != exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void modelReset();
        mPhase   = M_OFF;
        mIdx     = 0;
        mSum     = 0;
        mCnt     = 0;
        mAvgCh   = 0;
        mAvgData = 0;
        mErr     = 1'b0;
    endfunction

    function automatic void modelStep(input bit en, input bit rdy, input bit rv,
                                      input int rch, input int rdata);
        if (rv && mPhase != M_WAIT) mErr = 1'b1;
        case (mPhase)
            M_OFF: if (en) begin
                mPhase = M_REQ; mIdx = 0; mSum = 0; mCnt = 0;
            end
            M_REQ: if (rdy) mPhase = M_WAIT;
                   else if (!en) begin mPhase = M_OFF; mSum = 0; mCnt = 0; mIdx = 0; end
            M_WAIT: if (rv) begin
                if (rch == CH_BASE + mIdx) begin
                    mSum += rdata;
                    mCnt++;
                end else begin
                    mErr = 1'b1;
                end
                if (mCnt == NSAMP) begin
                    mPhase   = M_EMIT;
                    mAvgCh   = CH_BASE + mIdx;
                    mAvgData = mSum / NSAMP;
                end else if (en) begin
                    mPhase = M_REQ;
                end else begin
                    mPhase = M_OFF; mSum = 0; mCnt = 0; mIdx = 0;
                end
            end
            M_EMIT: begin
                mSum   = 0;
                mCnt   = 0;
                mIdx   = (mIdx + 1) % NCH;
                mPhase = en ? M_REQ : M_OFF;
            end
            default: mPhase = M_OFF;
        endcase
    endfunction

    task automatic checkOutput();
        bit req;
        req = (mPhase == M_REQ);
        check("command_valid", command_valid, req);
        check("command_channel", command_channel, req ? CH_BASE + mIdx : 0);
        check("command_sop", command_startofpacket, req);
        check("command_eop", command_endofpacket, req);
        check("avg_valid", avg_valid, mPhase == M_EMIT);
        check("avg_channel", avg_channel, mAvgCh);
        check("avg_data", avg_data, mAvgData);
        check("err_chan", err_chan, mErr);
    endtask

    // Called just after a falling edge; drives inputs for the next rising edge.
    task automatic applyStimulus(input bit en, input bit rdy, input bit rv,
                                 input int rch, input int rdata);
        enable           = en;
        command_ready    = rdy;
        response_valid   = rv;
        response_channel = 5'(rch);
        response_data    = 12'(rdata);
        modelStep(en, rdy, rv, rch, rdata);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic sampleOne(input int ch, input int data);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 1, ch, data);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        check("reset_command_valid", command_valid, 0);
        check("reset_command_channel", command_channel, 0);
        check("reset_sop", command_startofpacket, 0);
        check("reset_eop", command_endofpacket, 0);
        check("reset_avg_valid", avg_valid, 0);
        check("reset_avg_channel", avg_channel, 0);
        check("reset_avg_data", avg_data, 0);
        check("reset_err_chan", err_chan, 0);
        modelReset();
        enable         = 1'b0;
        command_ready  = 1'b0;
        response_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput();
    endtask

    initial begin
        bit en, rdy, rv;
        int rch, rdata;
        rst_n            = 1'b1;
        enable           = 1'b0;
        command_ready    = 1'b0;
        response_valid   = 1'b0;
        response_channel = '0;
        response_data    = '0;
        modelReset();
        @(negedge clk);
        doReset();

        $display("[TB] scenario 1: average of 100,200,300,400 on ch1");
        applyStimulus(1, 0, 0, 0, 0);
        check("t1_first_channel", command_channel, 1);
        sampleOne(1, 100);
        sampleOne(1, 200);
        sampleOne(1, 300);
        sampleOne(1, 400);
        check("t1_avg_valid", avg_valid, 1);
        check("t1_avg_channel", avg_channel, 1);
        check("t1_avg_data", avg_data, 250);
        applyStimulus(1, 1, 0, 0, 0);
        check("t1_next_channel", command_channel, 2);

        $display("[TB] scenario 2: full-scale samples on ch2 and wrap");
        for (int i = 0; i < NSAMP; i++) sampleOne(2, 4095);
        check("t2_avg_channel", avg_channel, 2);
        check("t2_avg_data", avg_data, 4095);
        applyStimulus(1, 0, 0, 0, 0);
        check("t2_wrap_channel", command_channel, 1);

        $display("[TB] scenario 3: command held while ready is low");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 0, 0, 0);
            check("t3_hold_valid", command_valid, 1);
            check("t3_hold_channel", command_channel, 1);
        end
        applyStimulus(1, 1, 0, 0, 0);
        check("t3_single_command", command_valid, 0);
        applyStimulus(1, 1, 1, 1, 10);

        $display("[TB] scenario 4: wrong response channel");
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 1, 7, 555);
        check("t4_err_set", err_chan, 1);
        check("t4_rerequest", command_channel, 1);
        sampleOne(1, 20);
        sampleOne(1, 30);
        sampleOne(1, 40);
        check("t4_avg_valid", avg_valid, 1);
        check("t4_avg_data", avg_data, 25);
        check("t4_err_sticky", err_chan, 1);
        applyStimulus(1, 0, 0, 0, 0);

        $display("[TB] scenario 5: enable dropped with a conversion outstanding");
        doReset();
        applyStimulus(1, 0, 0, 0, 0);
        sampleOne(1, 1000);
        sampleOne(1, 2000);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        check("t5_still_waiting", command_valid, 0);
        applyStimulus(0, 0, 1, 1, 3000);
        check("t5_no_avg", avg_valid, 0);
        check("t5_avg_data_untouched", avg_data, 0);
        check("t5_err_clear", err_chan, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        check("t5_idle", command_valid, 0);
        applyStimulus(1, 0, 0, 0, 0);
        check("t5_restart_channel", command_channel, 1);
        for (int i = 0; i < NSAMP; i++) sampleOne(1, 4);
        check("t5_avg_channel", avg_channel, 1);
        check("t5_avg_data", avg_data, 4);

        $display("[TB] scenario 6: reset while requesting, then stray response");
        applyStimulus(1, 0, 0, 0, 0);
        check("t6_in_cmd", command_valid, 1);
        doReset();
        applyStimulus(0, 0, 1, 2, 77);
        check("t6_stray_err", err_chan, 1);

        $display("[TB] randomized traffic");
        doReset();
        en = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 39) == 0) en = !en;
            rdy   = ($urandom_range(0, 3) != 0);
            rv    = 1'b0;
            rch   = 0;
            rdata = 0;
            if (mPhase == M_WAIT && $urandom_range(0, 1) == 1) begin
                rv    = 1'b1;
                rdata = int'($urandom_range(0, 4095));
                rch   = ($urandom_range(0, 199) == 0) ? 9 : CH_BASE + mIdx;
            end
            applyStimulus(en, rdy, rv, rch, rdata);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
